alu_serial_seq: RTL and testbench

Bit-serial sequencer that drives the 1-bit ALU slice: it accepts full-width operands and a 4-bit ALU control code, presents one bit pair per cycle (LSB first) to the slice, feeds the slice carry-out back as next carry-in, and assembles the result word and flags. It sits directly upstream and downstream of a single slice instance, replacing a 32-slice ripple array where area matters more than latency.

---
 rtl/alu_serial_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_serial_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer around a single 1-bit ALU slice: streams operand bits LSB first,
// recirculates the slice carry and assembles the result word plus zero/carry/overflow flags.
module alu_serial_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             slice_src1_o,
    output logic             slice_src2_o,
    output logic             slice_less_o,
    output logic             slice_A_invert_o,
    output logic             slice_B_invert_o,
    output logic             slice_cin_o,
    output logic [1:0]       slice_operation_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i
);

    localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-2:0] a_q, a_d;
    logic [WIDTH-2:0] b_q, b_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             s_src1_q, s_src1_d;
    logic             s_src2_q, s_src2_d;
    logic             s_ainv_q, s_ainv_d;
    logic             s_binv_q, s_binv_d;
    logic             s_cin_q, s_cin_d;
    logic [1:0]       s_op_q, s_op_d;

    logic             dec_ainv, dec_binv, dec_cin;
    logic [1:0]       dec_op;
    logic             is_arith, is_slt, ovf_msb, sum_msb, slt_set;
    logic [WIDTH-1:0] word_c, final_c;

    // Control decode; unknown codes fall back to AND
    always_comb begin
        dec_ainv = 1'b0;
        dec_binv = 1'b0;
        dec_op   = 2'b00;
        dec_cin  = 1'b0;
        case (ctrl_i)
            4'b0001: dec_op = 2'b01;
            4'b0010: dec_op = 2'b10;
            4'b0110: begin dec_binv = 1'b1; dec_op = 2'b10; dec_cin = 1'b1; end
            4'b0111: begin dec_binv = 1'b1; dec_op = 2'b11; dec_cin = 1'b1; end
            4'b1100: begin dec_ainv = 1'b1; dec_binv = 1'b1; end
            default: dec_op = 2'b00;
        endcase
    end

    // MSB-cycle flag logic; the slice emits `less` for SLT, so the sum bit is rebuilt here
    always_comb begin
        is_arith = s_op_q[1];
        is_slt   = (s_op_q == 2'b11);
        ovf_msb  = is_arith & (s_cin_q ^ slice_cout_i);
        sum_msb  = s_src1_q ^ ~s_src2_q ^ s_cin_q;
        slt_set  = sum_msb ^ ovf_msb;
        word_c   = {slice_result_i, acc_q};
        final_c  = is_slt ? WIDTH'(slt_set) : word_c;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        s_src1_d = s_src1_q;
        s_src2_d = s_src2_q;
        s_ainv_d = s_ainv_q;
        s_binv_d = s_binv_q;
        s_cin_d  = s_cin_q;
        s_op_d   = s_op_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d  = ST_RUN;
                    idx_d    = '0;
                    a_d      = src1_i[WIDTH-1:1];
                    b_d      = src2_i[WIDTH-1:1];
                    acc_d    = '0;
                    s_src1_d = src1_i[0];
                    s_src2_d = src2_i[0];
                    s_ainv_d = dec_ainv;
                    s_binv_d = dec_binv;
                    s_op_d   = dec_op;
                    s_cin_d  = dec_cin;
                end
            end
            ST_RUN: begin
                acc_d    = word_c[WIDTH-1:1];
                s_cin_d  = slice_cout_i;
                s_src1_d = a_q[0];
                s_src2_d = b_q[0];
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    state_d  = ST_DONE;
                    idx_d    = '0;
                    result_d = final_c;
                    zero_d   = ~|final_c;
                    cout_d   = is_arith & slice_cout_i;
                    ovf_d    = ovf_msb;
                    s_src1_d = 1'b0;
                    s_src2_d = 1'b0;
                    s_ainv_d = 1'b0;
                    s_binv_d = 1'b0;
                    s_cin_d  = 1'b0;
                    s_op_d   = 2'b00;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_src1_q    <= 1'b0;
            s_src2_q    <= 1'b0;
            s_ainv_q    <= 1'b0;
            s_binv_q    <= 1'b0;
            s_cin_q     <= 1'b0;
            s_op_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            s_src1_q    <= s_src1_d;
            s_src2_q    <= s_src2_d;
            s_ainv_q    <= s_ainv_d;
            s_binv_q    <= s_binv_d;
            s_cin_q     <= s_cin_d;
            s_op_q      <= s_op_d;
        end
    end

    assign in_ready_o        = in_ready_q;
    assign out_valid_o       = out_valid_q;
    assign result_o          = result_q;
    assign zero_o            = zero_q;
    assign cout_o            = cout_q;
    assign overflow_o        = ovf_q;
    assign slice_src1_o      = s_src1_q;
    assign slice_src2_o      = s_src2_q;
    assign slice_less_o      = 1'b0;
    assign slice_A_invert_o  = s_ainv_q;
    assign slice_B_invert_o  = s_binv_q;
    assign slice_cin_o       = s_cin_q;
    assign slice_operation_o = s_op_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: behavioural 1-bit slice, word-level reference model and
// an expected-result queue compared when the sequencer presents its output.
module tb_alu_serial_seq;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] src1, src2, result;
    logic [3:0]   ctrl;
    logic         zero, cout, ovf;
    logic         s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_res, s_cout;
    logic [1:0]   s_op;
    logic         sa, sbb;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .src1_i(src1), .src2_i(src2), .ctrl_i(ctrl),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .zero_o(zero), .cout_o(cout), .overflow_o(ovf),
        .slice_src1_o(s_src1), .slice_src2_o(s_src2), .slice_less_o(s_less),
        .slice_A_invert_o(s_ainv), .slice_B_invert_o(s_binv), .slice_cin_o(s_cin),
        .slice_operation_o(s_op),
        .slice_result_i(s_res), .slice_cout_i(s_cout)
    );

    // Behavioural 1-bit ALU slice
    always_comb begin
        sa  = s_src1 ^ s_ainv;
        sbb = s_src2 ^ s_binv;
        case (s_op)
            2'b00:   s_res = sa & sbb;
            2'b01:   s_res = sa | sbb;
            2'b10:   s_res = sa ^ sbb ^ s_cin;
            default: s_res = s_less;
        endcase
        s_cout = (sa & sbb) | (sa & s_cin) | (sbb & s_cin);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        exp_t e;
        logic [W:0] t;
        e = '0;
        case (c)
            4'b0001: e.r = a | b;
            4'b1100: e.r = ~(a | b);
            4'b0010: begin
                t   = {1'b0, a} + {1'b0, b};
                e.r = t[W-1:0];
                e.c = t[W];
                e.o = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
            end
            4'b0110, 4'b0111: begin
                t   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                e.c = t[W];
                e.o = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
                if (c == 4'b0110) e.r = t[W-1:0];
                else              e.r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            end
            default: e.r = a & b;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // One operation: accept, latency, optional backpressure, scoreboard compare, handshake
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                         input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        check("ready_idle", W'(in_ready), W'(1));
        src1 = a; src2 = b; ctrl = c; in_valid = 1'b1;
        sb.push_back(model(a, b, c));
        @(negedge clk);
        in_valid = 1'b0;
        src1 = $urandom; src2 = $urandom; ctrl = 4'b0110;
        check("ready_busy", W'(in_ready), W'(0));
        cyc = 0;
        while (!out_valid && cyc < 4 * W) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", W'(cyc), W'(W));
        if (sb.size() == 0) begin
            check("sb_underflow", W'(1), W'(0));
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) begin
                in_valid = 1'b1;
                @(negedge clk);
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_result", result, e.r);
            end
            in_valid = 1'b0;
            check("hold_ready", W'(in_ready), W'(0));
        end
        check("result", result, e.r);
        check("zero", W'(zero), W'(e.z));
        check("cout", W'(cout), W'(e.c));
        check("overflow", W'(ovf), W'(e.o));
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", W'(out_valid), W'(0));
    endtask

    initial begin
        logic [3:0] codes [7];
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0101};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; ctrl = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", W'(in_ready), W'(1));
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_result", result, '0);
        check("rst_flags", W'({zero, cout, ovf}), W'(0));
        rst_n = 1'b1;

        do_op(32'd7, 32'd5, 4'b0010, 0);
        do_op(32'd5, 32'd5, 4'b0110, 0);
        do_op(32'h7FFFFFFF, 32'd1, 4'b0010, 0);
        do_op(32'hFFFFFFFF, 32'd1, 4'b0111, 0);
        do_op(32'h7FFFFFFF, 32'h80000000, 4'b0111, 0);
        do_op(32'd3, 32'd3, 4'b0111, 0);
        do_op(32'd0, 32'd0, 4'b1100, 0);
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 0);
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 0);
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b1111, 0);
        do_op(32'h80000000, 32'h80000000, 4'b0010, 10);
        do_op(32'd100, 32'd42, 4'b0110, 0);

        // Abort mid-RUN; the op must never surface
        @(negedge clk);
        src1 = 32'h12345678; src2 = 32'h11111111; ctrl = 4'b0010; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_valid", W'(out_valid), W'(0));
        check("abort_ready", W'(in_ready), W'(1));
        check("abort_result", result, '0);
        check("abort_flags", W'({zero, cout, ovf}), W'(0));
        check("abort_slice", W'({s_src1, s_src2, s_ainv, s_binv, s_cin, s_op}), W'(0));
        do_op(32'd1000, 32'd2345, 4'b0010, 0);

        for (int i = 0; i < 8; i++) begin
            do_op($urandom, $urandom, codes[$urandom_range(0, 6)], (i == 3) ? 2 : 0);
        end

        check("sb_empty", W'(sb.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
